// File: rtl/ddr_mem_pkg.sv
// Shared types and helpers for the DDR burst memory model: FSM state encoding,
// beat-counter sizing and the per-word parity function.
package ddr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // A two-word burst has a single beat but still needs a 1-bit counter
    function automatic int beat_cnt_w(input int burst_len);
        int w;
        w = $clog2(burst_len / 2);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ddr_burst_addr_gen.sv
// Combinational wrapped-burst address generator: maps the burst base and beat
// index to the rise/fall word addresses, wrapping inside the aligned block.
module ddr_burst_addr_gen
    import ddr_mem_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = beat_cnt_w(BURST_LEN)
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [CNT_W-1:0]  i_beat,
    output logic [ADDR_W-1:0] o_rise_addr,
    output logic [ADDR_W-1:0] o_fall_addr
);

    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(BURST_LEN - 1);

    logic [ADDR_W-1:0] w_k_rise;
    logic [ADDR_W-1:0] w_k_fall;

    // Each beat carries words 2b and 2b+1; only the in-block offset bits move
    assign w_k_rise    = ADDR_W'({i_beat, 1'b0});
    assign w_k_fall    = w_k_rise + ADDR_W'(1);
    assign o_rise_addr = (i_base & ~MASK) | ((i_base + w_k_rise) & MASK);
    assign o_fall_addr = (i_base & ~MASK) | ((i_base + w_k_fall) & MASK);

endmodule

// File: rtl/ddr_burst_mem.sv
// Double-data-rate burst memory: two words per clock on a double-width bus,
// wrapped bursts of BURST_LEN words. Optional parity via DDR_MEM_PARITY_EN.
module ddr_burst_mem
    import ddr_mem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_rw,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [2*DATA_W-1:0] wr_data,
    output logic                rd_valid,
    output logic [2*DATA_W-1:0] rd_data,
    output logic                rd_last
`ifdef DDR_MEM_PARITY_EN
    ,
    output logic [1:0]          rd_perr
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NBEAT = BURST_LEN / 2;
    localparam int CNT_W = beat_cnt_w(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_beat;
    logic [ADDR_W-1:0]   w_rise_addr;
    logic [ADDR_W-1:0]   w_fall_addr;
    logic                w_last;
    logic                w_wr_fire;
    logic                w_rd_issue;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_rd_valid;
    logic                r_rd_last;
    logic [2*DATA_W-1:0] r_rd_data;

    ddr_burst_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_addr_gen (
        .i_base      (r_base),
        .i_beat      (r_beat),
        .o_rise_addr (w_rise_addr),
        .o_fall_addr (w_fall_addr)
    );

    assign w_last     = (r_beat == LAST_BEAT);
    assign w_wr_fire  = (r_state == WRITE) && wr_valid;
    assign w_rd_issue = (r_state == READ);

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = cmd_rw ? WRITE : READ;
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid && w_last) w_next = IDLE;
            end
            READ: begin
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (cmd_valid && cmd_ready) begin
                r_base <= cmd_addr & ~ADDR_W'(1);
                r_beat <= '0;
            end else if (w_wr_fire || w_rd_issue) begin
                r_beat <= r_beat + CNT_W'(1);
            end
        end
    end

    // Array is deliberately left unreset so committed words survive a reset
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_rise_addr] <= wr_data[DATA_W-1:0];
            r_mem[w_fall_addr] <= wr_data[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_issue;
            r_rd_last  <= w_rd_issue && w_last;
            if (w_rd_issue) r_rd_data <= {r_mem[w_fall_addr], r_mem[w_rise_addr]};
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign rd_data  = r_rd_data;

`ifdef DDR_MEM_PARITY_EN
    logic       r_par [DEPTH];
    logic [1:0] r_rd_perr;

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_par[w_rise_addr] <= even_parity(64'(wr_data[DATA_W-1:0]));
            r_par[w_fall_addr] <= even_parity(64'(wr_data[2*DATA_W-1:DATA_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_perr <= 2'b00;
        end else if (w_rd_issue) begin
            r_rd_perr <= {even_parity(64'(r_mem[w_fall_addr])) ^ r_par[w_fall_addr],
                          even_parity(64'(r_mem[w_rise_addr])) ^ r_par[w_rise_addr]};
        end
    end

    assign rd_perr = r_rd_perr;
`endif

endmodule

// File: tb/tb_ddr_burst_mem.sv
// Self-checking bench for ddr_burst_mem: directed bursts plus randomized
// command streams compared every cycle against a word-array burst model.
module tb_ddr_burst_mem;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int BURST_LEN = 4;
    localparam int NBEAT     = BURST_LEN / 2;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic                cmd_rw = 1'b0;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [2*DATA_W-1:0] wr_data = '0;
    logic                rd_valid;
    logic [2*DATA_W-1:0] rd_data;
    logic                rd_last;
`ifdef DDR_MEM_PARITY_EN
    logic [1:0]          rd_perr;
`endif

    ddr_burst_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last)
`ifdef DDR_MEM_PARITY_EN
        ,
        .rd_perr   (rd_perr)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                  at;
        logic [2*DATA_W-1:0] data;
        logic                last;
        logic [1:0]          perr;
    } beat_t;

    beat_t               exp_q[$];
    logic [DATA_W-1:0]   mem_m [DEPTH];
    logic                corrupt_m [DEPTH];
    logic [2*DATA_W-1:0] wdata_q[$];
    int                  m_idle_cyc = 0;
    bit                  m_in_write = 1'b0;
    logic [2*DATA_W-1:0] m_last_data = '0;
    int                  n_tests = 0;
    int                  n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Word k of a burst starting at addr, wrapped inside its aligned block
    function automatic int waddr(input int addr, input int k);
        int b;
        b = addr & ~1;
        return (b & ~(BURST_LEN - 1)) | ((b + k) % BURST_LEN);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(cyc >= m_idle_cyc));
            chk("wr_ready", 64'(wr_ready), 64'(m_in_write));
            while (exp_q.size() > 0 && exp_q[0].at < cyc) void'(exp_q.pop_front());
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                chk("rd_valid", 64'(rd_valid), 64'(1));
                chk("rd_data", 64'(rd_data), 64'(exp_q[0].data));
                chk("rd_last", 64'(rd_last), 64'(exp_q[0].last));
`ifdef DDR_MEM_PARITY_EN
                chk("rd_perr", 64'(rd_perr), 64'(exp_q[0].perr));
`endif
                m_last_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end else begin
                chk("rd_valid_idle", 64'(rd_valid), 64'(0));
                chk("rd_last_idle", 64'(rd_last), 64'(0));
                chk("rd_data_hold", 64'(rd_data), 64'(m_last_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_cmd();
        cmd_rw   = 1'($urandom);
        cmd_addr = ADDR_W'($urandom);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        #1;
        exp_q.delete();
        m_idle_cyc  = 0;
        m_in_write  = 1'b0;
        m_last_data = '0;
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_last", 64'(rd_last), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One command; reads return right after acceptance, writes after the
    // last beat (or after beat abort_after, followed by a reset)
    task automatic issue(input bit rw, input int addr, input bit hold,
                         input int smin, input int smax, input int abort_after);
        int a;
        logic [2*DATA_W-1:0] d;
        if (hold) begin
            cmd_valid = 1'b1;
            cmd_rw    = rw;
            cmd_addr  = ADDR_W'(addr);
        end
        while (cyc < m_idle_cyc) begin
            tick();
            if (!hold) junk_cmd();
        end
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = ADDR_W'(addr);
        wr_valid  = 1'b0;
        tick();
        a = cyc;
        cmd_valid = 1'b0;
        junk_cmd();
        if (!rw) begin
            for (int k = 0; k < NBEAT; k++) begin
                beat_t e;
                e.at   = a + k + 1;
                e.data = {mem_m[waddr(addr, 2*k+1)], mem_m[waddr(addr, 2*k)]};
                e.last = (k == NBEAT - 1);
                e.perr = {corrupt_m[waddr(addr, 2*k+1)], corrupt_m[waddr(addr, 2*k)]};
                exp_q.push_back(e);
            end
            m_idle_cyc = a + NBEAT;
        end else begin
            m_in_write = 1'b1;
            m_idle_cyc = 32'h7fff_ffff;
            for (int b = 0; b < NBEAT; b++) begin
                int stall;
                stall = $urandom_range(smax, smin);
                for (int s = 0; s < stall; s++) begin
                    wr_valid = 1'b0;
                    wr_data  = 16'($urandom);
                    tick();
                end
                d = (wdata_q.size() > 0) ? wdata_q.pop_front() : 16'($urandom);
                wr_valid = 1'b1;
                wr_data  = d;
                tick();
                wr_valid = 1'b0;
                mem_m[waddr(addr, 2*b)]       = d[DATA_W-1:0];
                mem_m[waddr(addr, 2*b+1)]     = d[2*DATA_W-1:DATA_W];
                corrupt_m[waddr(addr, 2*b)]   = 1'b0;
                corrupt_m[waddr(addr, 2*b+1)] = 1'b0;
                if (b == abort_after) begin
                    do_reset();
                    return;
                end
            end
            m_in_write = 1'b0;
            m_idle_cyc = cyc;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]     = '0;
            corrupt_m[i] = 1'b0;
        end
        do_reset();

        // Write at 0, then check model contents and cmd_ready return
        wdata_q.push_back(16'h1100);
        wdata_q.push_back(16'h3322);
        issue(1'b1, 0, 1'b0, 0, 0, -1);
        chk("t1_ready_back", 64'(cmd_ready), 64'(1));
        chk("t1_mem0", 64'(mem_m[0]), 64'h00);
        chk("t1_mem1", 64'(mem_m[1]), 64'h11);
        chk("t1_mem2", 64'(mem_m[2]), 64'h22);
        chk("t1_mem3", 64'(mem_m[3]), 64'h33);

        // Write at 5 (forced to 4) with three stall cycles before each beat
        wdata_q.push_back(16'h5544);
        wdata_q.push_back(16'h7766);
        issue(1'b1, 5, 1'b0, 3, 3, -1);
        chk("t3_mem4", 64'(mem_m[4]), 64'h44);
        chk("t3_mem7", 64'(mem_m[7]), 64'h77);

        // Read at 2 wraps to 3322 then 1100
        issue(1'b0, 2, 1'b0, 0, 0, -1);
        chk("t2_model_beat0", 64'(exp_q[0].data), 64'h3322);
        chk("t2_model_beat1", 64'(exp_q[1].data), 64'h1100);
        tick();
        chk("t2_beat0", 64'(rd_data), 64'h3322);
        chk("t2_valid0", 64'(rd_valid), 64'(1));
        tick();
        chk("t2_beat1", 64'(rd_data), 64'h1100);
        chk("t2_last1", 64'(rd_last), 64'(1));

        // Back-to-back read then write with cmd_valid held through the read
        issue(1'b0, 4, 1'b0, 0, 0, -1);
        wdata_q.push_back(16'hBBAA);
        wdata_q.push_back(16'hDDCC);
        issue(1'b1, 1, 1'b1, 0, 1, -1);
        issue(1'b0, 0, 1'b0, 0, 0, -1);
        issue(1'b0, 4, 1'b0, 0, 0, -1);

        // Reset after the first write beat: only words 4,5 change
        wdata_q.push_back(16'hA9A8);
        wdata_q.push_back(16'hFFFE);
        issue(1'b1, 4, 1'b0, 0, 0, 0);
        chk("t4_mem6_kept", 64'(mem_m[6]), 64'h66);
        issue(1'b0, 4, 1'b0, 0, 0, -1);

        // Reset while a read burst is on the bus
        issue(1'b0, 6, 1'b0, 0, 0, -1);
        @(negedge clk);
        #1;
        do_reset();
        issue(1'b0, 6, 1'b0, 0, 0, -1);

`ifdef DDR_MEM_PARITY_EN
        wdata_q.push_back(16'h1100);
        wdata_q.push_back(16'h3322);
        issue(1'b1, 0, 1'b0, 0, 0, -1);
        tick();
        dut.r_mem[1] = dut.r_mem[1] ^ 8'h01;
        mem_m[1]     = mem_m[1] ^ 8'h01;
        corrupt_m[1] = 1'b1;
        issue(1'b0, 0, 1'b0, 0, 0, -1);
        chk("t6_model_perr0", 64'(exp_q[0].perr), 64'(2'b10));
        chk("t6_model_perr1", 64'(exp_q[1].perr), 64'(2'b00));
        tick();
        chk("t6_perr0", 64'(rd_perr), 64'(2'b10));
        tick();
        chk("t6_perr1", 64'(rd_perr), 64'(2'b00));
`endif

        for (int n = 0; n < 80; n++) begin
            issue(1'($urandom), int'($urandom_range(DEPTH - 1, 0)), 1'($urandom),
                  0, 2, -1);
        end
        while (cyc <= m_idle_cyc + 1) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
